// File: rtl/matmul_seq_ctrl.sv
// matmul_seq_ctrl: sequencer for the MAX_DIM x MAX_DIM systolic PE array.
// It latches the N/K/M dimensions on start and issues a one-cycle accumulator
// clear. It then drives the skewed per-row A and per-column B injection
// schedule. After the drain wait it pulses done_o.
//
// Optional feature macro: MATMUL_SEQ_CTRL_ERR_EN
//   defined   : illegal dims (0 or > MAX_DIM) reject the start and pulse err_o
//   undefined : err_o tied 0, dims clamped to 1..MAX_DIM when latched
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start_i; dims latched on the accepting cycle
// CLEAR | one cycle, pe_clear_o=1
// FEED  | feed step t = 0..T-1 (T = N+K+M-2), skewed A/B injection
// DRAIN | DRAIN_LAT cycles for the last partial sums to settle
// DONE  | one cycle, done_o=1; results may be captured
module matmul_seq_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int BUS_WIDTH  = 64,
  parameter int MAX_DIM    = BUS_WIDTH / DATA_WIDTH,
  parameter int DRAIN_LAT  = 1,
  localparam int DIM_W = $clog2(MAX_DIM) + 1,
  localparam int IDX_W = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1,
  localparam int CNT_W = $clog2(3 * MAX_DIM + DRAIN_LAT + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [DIM_W-1:0]         N_i,
  input  logic [DIM_W-1:0]         K_i,
  input  logic [DIM_W-1:0]         M_i,
  output logic                     busy_o,
  output logic                     pe_clear_o,
  output logic [MAX_DIM-1:0]       a_valid_o,
  output logic [MAX_DIM*IDX_W-1:0] a_k_o,
  output logic [MAX_DIM-1:0]       b_valid_o,
  output logic [MAX_DIM*IDX_W-1:0] b_k_o,
  output logic                     done_o,
  output logic                     err_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state;
  logic [DIM_W-1:0]  n_q;
  logic [DIM_W-1:0]  k_q;
  logic [DIM_W-1:0]  m_q;
  logic [CNT_W-1:0]  t_q;
  logic [CNT_W-1:0]  t_last_q;
  logic [CNT_W-1:0]  drain_q;

  // Lane i (row or column) is active at step t when it exists and the
  // skewed window [i, i+K) covers t.
  function automatic logic lane_on(input logic [CNT_W-1:0] t, input int i,
                                   input logic [DIM_W-1:0] lim,
                                   input logic [DIM_W-1:0] kd);
    return (i < int'(lim)) && (int'(t) >= i) && ((int'(t) - i) < int'(kd));
  endfunction

  function automatic logic [MAX_DIM-1:0] valid_vec(input logic [CNT_W-1:0] t,
                                                   input logic [DIM_W-1:0] lim,
                                                   input logic [DIM_W-1:0] kd);
    logic [MAX_DIM-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_DIM; i++) v[i] = lane_on(t, i, lim, kd);
    return v;
  endfunction

  // k index is t-i on an active lane and 0 otherwise, so idle lanes stay quiet.
  function automatic logic [MAX_DIM*IDX_W-1:0] kidx_vec(input logic [CNT_W-1:0] t,
                                                        input logic [DIM_W-1:0] lim,
                                                        input logic [DIM_W-1:0] kd);
    logic [MAX_DIM*IDX_W-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_DIM; i++) begin
      if (lane_on(t, i, lim, kd)) v[i*IDX_W +: IDX_W] = IDX_W'(int'(t) - i);
    end
    return v;
  endfunction

  // Index of the final feed step, T-1 = N+K+M-3.
  function automatic logic [CNT_W-1:0] last_step(input logic [DIM_W-1:0] n,
                                                 input logic [DIM_W-1:0] k,
                                                 input logic [DIM_W-1:0] m);
    return CNT_W'(n) + CNT_W'(k) + CNT_W'(m) - CNT_W'(3);
  endfunction

`ifdef MATMUL_SEQ_CTRL_ERR_EN
  function automatic logic dim_ok(input logic [DIM_W-1:0] d);
    return (d != '0) && (int'(d) <= MAX_DIM);
  endfunction
`else
  function automatic logic [DIM_W-1:0] clamp_dim(input logic [DIM_W-1:0] d);
    if (d == '0) return DIM_W'(1);
    if (int'(d) > MAX_DIM) return DIM_W'(MAX_DIM);
    return d;
  endfunction

  assign err_o = 1'b0;
`endif

  // Sequencer FSM; all outputs are registered and decoded from next-step values
  // so they line up with the registered feed counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      n_q        <= '0;
      k_q        <= '0;
      m_q        <= '0;
      t_q        <= '0;
      t_last_q   <= '0;
      drain_q    <= '0;
      busy_o     <= 1'b0;
      pe_clear_o <= 1'b0;
      a_valid_o  <= '0;
      a_k_o      <= '0;
      b_valid_o  <= '0;
      b_k_o      <= '0;
      done_o     <= 1'b0;
`ifdef MATMUL_SEQ_CTRL_ERR_EN
      err_o      <= 1'b0;
`endif
    end else begin
      pe_clear_o <= 1'b0;
      done_o     <= 1'b0;
`ifdef MATMUL_SEQ_CTRL_ERR_EN
      err_o      <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (start_i) begin
`ifdef MATMUL_SEQ_CTRL_ERR_EN
            if (dim_ok(N_i) && dim_ok(K_i) && dim_ok(M_i)) begin
              n_q        <= N_i;
              k_q        <= K_i;
              m_q        <= M_i;
              t_last_q   <= last_step(N_i, K_i, M_i);
              state      <= CLEAR;
              busy_o     <= 1'b1;
              pe_clear_o <= 1'b1;
            end else begin
              err_o <= 1'b1;
            end
`else
            n_q        <= clamp_dim(N_i);
            k_q        <= clamp_dim(K_i);
            m_q        <= clamp_dim(M_i);
            t_last_q   <= last_step(clamp_dim(N_i), clamp_dim(K_i), clamp_dim(M_i));
            state      <= CLEAR;
            busy_o     <= 1'b1;
            pe_clear_o <= 1'b1;
`endif
          end
        end

        CLEAR: begin
          state     <= FEED;
          t_q       <= '0;
          a_valid_o <= valid_vec('0, n_q, k_q);
          a_k_o     <= kidx_vec('0, n_q, k_q);
          b_valid_o <= valid_vec('0, m_q, k_q);
          b_k_o     <= kidx_vec('0, m_q, k_q);
        end

        FEED: begin
          if (t_q == t_last_q) begin
            a_valid_o <= '0;
            a_k_o     <= '0;
            b_valid_o <= '0;
            b_k_o     <= '0;
            drain_q   <= CNT_W'(DRAIN_LAT - 1);
            if (DRAIN_LAT == 0) begin
              state  <= DONE;
              done_o <= 1'b1;
            end else begin
              state <= DRAIN;
            end
          end else begin
            t_q       <= t_q + CNT_W'(1);
            a_valid_o <= valid_vec(t_q + CNT_W'(1), n_q, k_q);
            a_k_o     <= kidx_vec(t_q + CNT_W'(1), n_q, k_q);
            b_valid_o <= valid_vec(t_q + CNT_W'(1), m_q, k_q);
            b_k_o     <= kidx_vec(t_q + CNT_W'(1), m_q, k_q);
          end
        end

        DRAIN: begin
          if (drain_q == '0) begin
            state  <= DONE;
            done_o <= 1'b1;
          end else begin
            drain_q <= drain_q - CNT_W'(1);
          end
        end

        DONE: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end

        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Directed bench for matmul_seq_ctrl in the default configuration (MAX_DIM=2).
module tb_matmul_seq_ctrl;

  localparam int MAXD  = 2;
  localparam int DIM_W = 2;
  localparam int IDX_W = 1;
  localparam int DL    = 1;

  logic                    clk_i = 1'b0;
  logic                    rst_i = 1'b1;
  logic                    start_i = 1'b0;
  logic [DIM_W-1:0]        N_i = '0;
  logic [DIM_W-1:0]        K_i = '0;
  logic [DIM_W-1:0]        M_i = '0;
  logic                    busy_o;
  logic                    pe_clear_o;
  logic [MAXD-1:0]         a_valid_o;
  logic [MAXD*IDX_W-1:0]   a_k_o;
  logic [MAXD-1:0]         b_valid_o;
  logic [MAXD*IDX_W-1:0]   b_k_o;
  logic                    done_o;
  logic                    err_o;

  int total = 0;
  int bad   = 0;

  matmul_seq_ctrl dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .N_i        (N_i),
    .K_i        (K_i),
    .M_i        (M_i),
    .busy_o     (busy_o),
    .pe_clear_o (pe_clear_o),
    .a_valid_o  (a_valid_o),
    .a_k_o      (a_k_o),
    .b_valid_o  (b_valid_o),
    .b_k_o      (b_k_o),
    .done_o     (done_o),
    .err_o      (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [MAXD-1:0] exp_valid(input int t, input int lim, input int kd);
    logic [MAXD-1:0] v;
    v = '0;
    for (int i = 0; i < MAXD; i++) v[i] = (i < lim) && (t >= i) && (t - i < kd);
    return v;
  endfunction

  function automatic logic [MAXD*IDX_W-1:0] exp_k(input int t, input int lim, input int kd);
    logic [MAXD*IDX_W-1:0] v;
    v = '0;
    for (int i = 0; i < MAXD; i++)
      if ((i < lim) && (t >= i) && (t - i < kd)) v[i*IDX_W +: IDX_W] = IDX_W'(t - i);
    return v;
  endfunction

  // Expected outputs at cycle c after the start was sampled, for effective dims.
  task automatic check_cycle(input string tag, input int c, input int n, input int k, input int m);
    int tt;
    logic feed;
    tt   = n + k + m - 2;
    feed = (c >= 2) && (c <= tt + 1);
    chk($sformatf("%s c%0d busy", tag, c), 32'(busy_o), 32'((c >= 1) && (c <= tt + DL + 2)));
    chk($sformatf("%s c%0d clr", tag, c), 32'(pe_clear_o), 32'(c == 1));
    chk($sformatf("%s c%0d done", tag, c), 32'(done_o), 32'(c == tt + DL + 2));
    chk($sformatf("%s c%0d err", tag, c), 32'(err_o), 32'(0));
    chk($sformatf("%s c%0d av", tag, c), 32'(a_valid_o), feed ? 32'(exp_valid(c - 2, n, k)) : 32'(0));
    chk($sformatf("%s c%0d ak", tag, c), 32'(a_k_o), feed ? 32'(exp_k(c - 2, n, k)) : 32'(0));
    chk($sformatf("%s c%0d bv", tag, c), 32'(b_valid_o), feed ? 32'(exp_valid(c - 2, m, k)) : 32'(0));
    chk($sformatf("%s c%0d bk", tag, c), 32'(b_k_o), feed ? 32'(exp_k(c - 2, m, k)) : 32'(0));
  endtask

  // One start pulse with dims (n,k,m); dims are scrambled after the start is
  // sampled, and the schedule is checked against effective dims (ne,ke,me).
  task automatic run(input int n, input int k, input int m,
                     input int ne, input int ke, input int me, input string tag);
    int last;
    N_i = DIM_W'(n); K_i = DIM_W'(k); M_i = DIM_W'(m);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    N_i = '0; K_i = '0; M_i = '0;
    last = ne + ke + me - 2 + DL + 2;
    for (int c = 1; c <= last + 1; c++) begin
      check_cycle(tag, c, ne, ke, me);
      if (c <= last) tick();
    end
  endtask

  initial begin
    logic [1:0] h_busy [1:8];
    logic [1:0] h_clr  [1:8];
    logic [1:0] h_vld  [1:8];
    logic [1:0] h_k    [1:8];
    logic [1:0] h_done [1:8];
    h_busy = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0};
    h_clr  = '{2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    h_vld  = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00};
    h_k    = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00};
    h_done = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0};

    // Reset holds everything at 0 even with start asserted.
    rst_i = 1'b1; start_i = 1'b1; N_i = 2'd2; K_i = 2'd2; M_i = 2'd2;
    tick(); tick();
    chk("rst busy", 32'(busy_o), 32'(0));
    chk("rst clr", 32'(pe_clear_o), 32'(0));
    chk("rst av", 32'(a_valid_o), 32'(0));
    chk("rst bv", 32'(b_valid_o), 32'(0));
    chk("rst done", 32'(done_o), 32'(0));
    chk("rst err", 32'(err_o), 32'(0));
    start_i = 1'b0; rst_i = 1'b0;
    tick();
    chk("idle busy", 32'(busy_o), 32'(0));

    // 2x2x2, hand-computed schedule.
    N_i = 2'd2; K_i = 2'd2; M_i = 2'd2; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      chk($sformatf("hand c%0d busy", c), 32'(busy_o), 32'(h_busy[c]));
      chk($sformatf("hand c%0d clr", c), 32'(pe_clear_o), 32'(h_clr[c]));
      chk($sformatf("hand c%0d av", c), 32'(a_valid_o), 32'(h_vld[c]));
      chk($sformatf("hand c%0d ak", c), 32'(a_k_o), 32'(h_k[c]));
      chk($sformatf("hand c%0d bv", c), 32'(b_valid_o), 32'(h_vld[c]));
      chk($sformatf("hand c%0d bk", c), 32'(b_k_o), 32'(h_k[c]));
      chk($sformatf("hand c%0d done", c), 32'(done_o), 32'(h_done[c]));
      if (c < 8) tick();
    end

    // Minimal and asymmetric shapes; dims scrambled mid-run.
    run(1, 1, 1, 1, 1, 1, "d111");
    run(1, 2, 2, 1, 2, 2, "d122");
    run(2, 1, 2, 2, 1, 2, "d212");
    run(2, 2, 1, 2, 2, 1, "d221");

`ifdef MATMUL_SEQ_CTRL_ERR_EN
    N_i = 2'd2; K_i = 2'd0; M_i = 2'd2; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("errk0 err", 32'(err_o), 32'(1));
    chk("errk0 busy", 32'(busy_o), 32'(0));
    chk("errk0 clr", 32'(pe_clear_o), 32'(0));
    tick();
    chk("errk0 err2", 32'(err_o), 32'(0));
    chk("errk0 busy2", 32'(busy_o), 32'(0));
    N_i = 2'd3; K_i = 2'd1; M_i = 2'd1; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("errn3 err", 32'(err_o), 32'(1));
    chk("errn3 busy", 32'(busy_o), 32'(0));
    tick();
`else
    run(3, 2, 2, 2, 2, 2, "clampn3");
    run(0, 3, 1, 1, 2, 1, "clamp0");
`endif

    // Back-to-back with start held: one idle cycle between done and clear.
    N_i = 2'd2; K_i = 2'd2; M_i = 2'd2; start_i = 1'b1;
    tick();
    N_i = 2'd1; K_i = 2'd1; M_i = 2'd1;
    for (int c = 1; c <= 7; c++) begin
      check_cycle("b2b1", c, 2, 2, 2);
      tick();
    end
    chk("b2b gap busy", 32'(busy_o), 32'(0));
    chk("b2b gap clr", 32'(pe_clear_o), 32'(0));
    chk("b2b gap done", 32'(done_o), 32'(0));
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 1) start_i = 1'b0;
      check_cycle("b2b2", c, 1, 1, 1);
    end

    // Reset during FEED at t=2.
    N_i = 2'd2; K_i = 2'd2; M_i = 2'd2; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick(); tick(); tick();
    chk("midrst pre av", 32'(a_valid_o), 32'(2'b10));
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("midrst busy", 32'(busy_o), 32'(0));
    chk("midrst av", 32'(a_valid_o), 32'(0));
    chk("midrst ak", 32'(a_k_o), 32'(0));
    chk("midrst bv", 32'(b_valid_o), 32'(0));
    chk("midrst bk", 32'(b_k_o), 32'(0));
    chk("midrst clr", 32'(pe_clear_o), 32'(0));
    chk("midrst done", 32'(done_o), 32'(0));
    for (int c = 0; c < 6; c++) begin
      tick();
      chk($sformatf("postrst c%0d done", c), 32'(done_o), 32'(0));
      chk($sformatf("postrst c%0d busy", c), 32'(busy_o), 32'(0));
    end
    run(2, 2, 2, 2, 2, 2, "afterrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/matmul_seq_ctrl.md
Name: matmul_seq_ctrl

Overview:
- Sequencer for the MAX_DIM x MAX_DIM systolic PE array of the matrix-multiply datapath.
- Latches dimensions N (rows of A), K (shared dimension) and M (columns of B) on start.
- Clears the PE accumulators, then drives the skewed per-row A and per-column B injection schedule (valid bit plus k index).
- Waits for propagation and drain, then pulses done_o so the result matrix can be captured.

Parameters:
- DATA_WIDTH, 32, element width; only used to derive MAX_DIM.
- BUS_WIDTH, 64, bus width.
- MAX_DIM, BUS_WIDTH/DATA_WIDTH, array dimension.
- DRAIN_LAT, 1, cycles after the last feed step before the results are stable.
- Localparams: DIM_W = $clog2(MAX_DIM)+1; IDX_W = max(1,$clog2(MAX_DIM)); CNT_W sized to hold 3*MAX_DIM+DRAIN_LAT.

Ports:
- clk_i  in  1  clock; all logic is on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  request to run one multiply.
- N_i  in  DIM_W  rows of A; actual value, legal range 1..MAX_DIM.
- K_i  in  DIM_W  columns of A / rows of B; legal range 1..MAX_DIM.
- M_i  in  DIM_W  columns of B; legal range 1..MAX_DIM.
- busy_o  out  1  high from CLEAR through DONE.
- pe_clear_o  out  1  one-cycle accumulator clear to all PEs.
- a_valid_o  out  MAX_DIM  bit i injects element A[i][a_k_o[i]] into row i.
- a_k_o  out  MAX_DIM*IDX_W  packed k index per row; row i occupies bits [i*IDX_W +: IDX_W].
- b_valid_o  out  MAX_DIM  bit j injects element B[b_k_o[j]][j] into column j.
- b_k_o  out  MAX_DIM*IDX_W  packed k index per column.
- done_o  out  1  one-cycle pulse; results are valid.
- err_o  out  1  one-cycle illegal-dimension pulse (see Optional Feature).

Behaviour:
- Reset: state = IDLE; all outputs 0; counter and latched dims cleared. Reset wins over every other event, including mid-run; there is no partial done_o.
- States and transitions:
  - IDLE -> CLEAR when start_i=1; N/K/M are latched in that cycle.
  - CLEAR lasts 1 cycle (pe_clear_o=1) -> FEED with t=0.
  - FEED runs t = 0..T-1, where T = K+N+M-2 -> DRAIN.
  - DRAIN lasts DRAIN_LAT cycles -> DONE.
  - DONE lasts 1 cycle (done_o=1) -> IDLE.
- start_i is ignored outside IDLE; there is no queuing. A start_i held high across DONE->IDLE starts a new run one cycle after DONE (one idle cycle between runs).
- busy_o = 1 in CLEAR, FEED, DRAIN and DONE.
- Feed decode during FEED, all outputs registered and aligned with counter t:
  - a_valid_o[i] = (i<N) && (t>=i) && (t-i<K); a_k_o[i] = t-i when valid, else 0.
  - b_valid_o[j] = (j<M) && (t>=j) && (t-j<K); b_k_o[j] = t-j when valid, else 0.
  - Outside FEED: all valid and k outputs are 0.
- The last FEED cycles may carry no valid bits. These cycles cover row/column propagation to PE(N-1,M-1).
- Latency: done_o is high exactly T+DRAIN_LAT+2 cycles after the cycle start_i was sampled.
- Dims of 1 are legal; for N=K=M=1, T=1.
- Dims change while busy: no effect; only the latched copies are used.

Optional Feature:
- Macro: MATMUL_SEQ_CTRL_ERR_EN.
- Defined: a start_i with any dim equal to 0 or greater than MAX_DIM does not start a run. err_o pulses 1 in the next cycle, the state stays IDLE, and busy_o stays 0.
- Undefined: err_o is tied 0. Dims are clamped to the range 1..MAX_DIM at latch time and the run proceeds with the clamped values.

Test Plan:
- MAX_DIM=2, N=K=M=2, DRAIN_LAT=1, start at cycle 0:
  - cycle 1: pe_clear_o=1.
  - FEED t=0: a_valid=01, b_valid=01.
  - t=1: a_valid=11, a_k={0,1}; b_valid=11.
  - t=2: a_valid=10, a_k[1]=1.
  - t=3: no valid bits.
  - done_o at cycle 7; busy_o high over cycles 1..7.
- MAX_DIM=4 (BUS_WIDTH=128), N=3, K=4, M=2:
  - T=7; a_valid_o[3]=0 and b_valid_o[3:2]=0 throughout.
  - done_o at cycle 10.
- N=K=M=1, MAX_DIM=2: single feed step with a_valid=01, b_valid=01, k=0; done_o at cycle 4.
- start_i held high continuously: runs back-to-back with exactly one idle cycle between done_o and the next pe_clear_o. Dims changed mid-run leave the schedule unchanged.
- rst_i asserted during FEED at t=2: the next cycle shows all outputs 0 and state IDLE; no done_o. A new start then produces the full schedule from t=0.
- With MATMUL_SEQ_CTRL_ERR_EN: K=0 -> err_o=1 for one cycle, busy_o=0.
- Without MATMUL_SEQ_CTRL_ERR_EN: N=3 with MAX_DIM=2 -> clamped to 2; the schedule equals the N=2 case and err_o=0.
